// File: rtl/svreal_alu_reg_if.sv
// Operand/result bundle for svreal_alu_reg. Widths must match the ALU instance
// it is connected to; exponents live only on the ALU because they never change
// the bit layout of the bus.
interface svreal_alu_reg_if #(
    parameter int A_WIDTH = 16,
    parameter int B_WIDTH = 16,
    parameter int C_WIDTH = 16
);
    logic                      in_valid;
    logic [2:0]                op;
    logic signed [A_WIDTH-1:0] a_value;
    logic signed [B_WIDTH-1:0] b_value;
    logic signed [C_WIDTH-1:0] c_value;
    logic [2:0]                cmp;
    logic                      out_valid;

    modport master (
        output in_valid, op, a_value, b_value,
        input  c_value, cmp, out_valid
    );

    modport slave (
        input  in_valid, op, a_value, b_value,
        output c_value, cmp, out_valid
    );
endinterface

// File: rtl/svreal_alu_reg.sv
// Registered fixed-point ALU for svreal numbers (real = value * 2^exp).
// All arithmetic is combinational from the bus inputs; a single output stage
// registers the realigned result, the {gt,eq,lt} flags and a valid bit.

// Realigns a signed fixed-point value from one exponent to another. Shifting
// right is arithmetic (floor toward -inf); the result wraps to the output
// width with no saturation.
module svreal_align #(
    parameter int IN_WIDTH  = 16,
    parameter int IN_EXP    = -8,
    parameter int OUT_WIDTH = 16,
    parameter int OUT_EXP   = -8
) (
    input  logic signed [IN_WIDTH-1:0]  i_x,
    output logic signed [OUT_WIDTH-1:0] o_y
);
    localparam int SHIFT = IN_EXP - OUT_EXP;
    localparam int SHL   = (SHIFT > 0) ? SHIFT : 0;
    localparam int SHR   = (SHIFT < 0) ? -SHIFT : 0;
    // Wide enough that a left shift keeps every output bit and a right shift
    // still sees the sign extension.
    localparam int WW    = IN_WIDTH + OUT_WIDTH + SHL;

    logic signed [WW-1:0] w_wide;

    assign w_wide = {{(WW-IN_WIDTH){i_x[IN_WIDTH-1]}}, i_x};
    assign o_y    = OUT_WIDTH'((w_wide <<< SHL) >>> SHR);
endmodule

module svreal_alu_reg #(
    parameter int A_WIDTH = 16,
    parameter int A_EXP   = -8,
    parameter int B_WIDTH = 16,
    parameter int B_EXP   = -8,
    parameter int C_WIDTH = 16,
    parameter int C_EXP   = -8
) (
    input  logic            clk,
    input  logic            rst_n,
    svreal_alu_reg_if.slave bus
);
    typedef enum logic [2:0] {
        OP_MUL  = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_NEG  = 3'd3,
        OP_MIN  = 3'd4,
        OP_MAX  = 3'd5,
        OP_PASS = 3'd6,
        OP_CMP  = 3'd7
    } opCode_t;

    // Full-precision product format.
    localparam int P_WIDTH = A_WIDTH + B_WIDTH;
    localparam int P_EXP   = A_EXP + B_EXP;

    // Compare format: the coarser exponent, with each operand narrowed by the
    // bits it loses so the right shift can never wrap.
    localparam int E_CMP    = (A_EXP > B_EXP) ? A_EXP : B_EXP;
    localparam int A_CMP_W  = A_WIDTH - (E_CMP - A_EXP);
    localparam int B_CMP_W  = B_WIDTH - (E_CMP - B_EXP);

    opCode_t                   w_op;
    logic signed [P_WIDTH-1:0] w_aExt;
    logic signed [P_WIDTH-1:0] w_bExt;
    logic signed [P_WIDTH-1:0] w_prod;
    logic signed [C_WIDTH-1:0] w_prodC;
    logic signed [C_WIDTH-1:0] w_aC;
    logic signed [C_WIDTH-1:0] w_bC;
    logic signed [A_CMP_W-1:0] w_aCmp;
    logic signed [B_CMP_W-1:0] w_bCmp;
    logic                      w_gt;
    logic                      w_eq;
    logic                      w_lt;
    logic signed [C_WIDTH-1:0] w_cNext;

    logic signed [C_WIDTH-1:0] r_cValue;
    logic [2:0]                r_cmp;
    logic                      r_outValid;

    assign w_op = opCode_t'(bus.op);

    assign w_aExt = {{B_WIDTH{bus.a_value[A_WIDTH-1]}}, bus.a_value};
    assign w_bExt = {{A_WIDTH{bus.b_value[B_WIDTH-1]}}, bus.b_value};
    assign w_prod = w_aExt * w_bExt;

    svreal_align #(
        .IN_WIDTH(P_WIDTH), .IN_EXP(P_EXP), .OUT_WIDTH(C_WIDTH), .OUT_EXP(C_EXP)
    ) u_alignProd (
        .i_x(w_prod), .o_y(w_prodC)
    );

    svreal_align #(
        .IN_WIDTH(A_WIDTH), .IN_EXP(A_EXP), .OUT_WIDTH(C_WIDTH), .OUT_EXP(C_EXP)
    ) u_alignA (
        .i_x(bus.a_value), .o_y(w_aC)
    );

    svreal_align #(
        .IN_WIDTH(B_WIDTH), .IN_EXP(B_EXP), .OUT_WIDTH(C_WIDTH), .OUT_EXP(C_EXP)
    ) u_alignB (
        .i_x(bus.b_value), .o_y(w_bC)
    );

    svreal_align #(
        .IN_WIDTH(A_WIDTH), .IN_EXP(A_EXP), .OUT_WIDTH(A_CMP_W), .OUT_EXP(E_CMP)
    ) u_alignACmp (
        .i_x(bus.a_value), .o_y(w_aCmp)
    );

    svreal_align #(
        .IN_WIDTH(B_WIDTH), .IN_EXP(B_EXP), .OUT_WIDTH(B_CMP_W), .OUT_EXP(E_CMP)
    ) u_alignBCmp (
        .i_x(bus.b_value), .o_y(w_bCmp)
    );

    // Both sides are signed, so the narrower one is sign-extended here.
    assign w_gt = (w_aCmp >  w_bCmp);
    assign w_eq = (w_aCmp == w_bCmp);
    assign w_lt = (w_aCmp <  w_bCmp);

    // Opcode decode; MIN/MAX reuse the compare flags so ordering matches cmp.
    always_comb begin
        w_cNext = '0;
        case (w_op)
            OP_MUL:  w_cNext = w_prodC;
            OP_ADD:  w_cNext = w_aC + w_bC;
            OP_SUB:  w_cNext = w_aC - w_bC;
            OP_NEG:  w_cNext = -w_aC;
            OP_MIN:  w_cNext = w_gt ? w_bC : w_aC;
            OP_MAX:  w_cNext = w_lt ? w_bC : w_aC;
            OP_PASS: w_cNext = w_aC;
            OP_CMP:  w_cNext = '0;
            default: w_cNext = '0;
        endcase
    end

    // Output stage: capture result and flags on valid, hold them otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cValue   <= '0;
            r_cmp      <= 3'b000;
            r_outValid <= 1'b0;
        end else begin
            r_outValid <= bus.in_valid;
            if (bus.in_valid) begin
                r_cValue <= w_cNext;
                r_cmp    <= {w_gt, w_eq, w_lt};
            end
        end
    end

    assign bus.c_value   = r_cValue;
    assign bus.cmp       = r_cmp;
    assign bus.out_valid = r_outValid;
endmodule

// File: tb/tb_svreal_alu_reg.sv
// Directed bench for svreal_alu_reg: one default-format instance and one
// mixed-format instance (A_EXP=-4, B_EXP=-8, C_WIDTH=12, C_EXP=-6).
module tb_svreal_alu_reg;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    svreal_alu_reg_if #(.A_WIDTH(16), .B_WIDTH(16), .C_WIDTH(16)) busA ();
    svreal_alu_reg_if #(.A_WIDTH(16), .B_WIDTH(16), .C_WIDTH(12)) busB ();

    svreal_alu_reg #(
        .A_WIDTH(16), .A_EXP(-8), .B_WIDTH(16), .B_EXP(-8), .C_WIDTH(16), .C_EXP(-8)
    ) dutA (
        .clk(clk), .rst_n(rst_n), .bus(busA.slave)
    );

    svreal_alu_reg #(
        .A_WIDTH(16), .A_EXP(-4), .B_WIDTH(16), .B_EXP(-8), .C_WIDTH(12), .C_EXP(-6)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .bus(busB.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Present a valid op to the default-format unit and step past the edge.
    task automatic applyStimulus(input logic [2:0] op, input logic signed [15:0] a,
                                 input logic signed [15:0] b);
        busA.in_valid = 1'b1;
        busA.op       = op;
        busA.a_value  = a;
        busA.b_value  = b;
        @(posedge clk);
        #1;
    endtask

    // Same for the mixed-format unit.
    task automatic applyStimulusMixed(input logic [2:0] op, input logic signed [15:0] a,
                                      input logic signed [15:0] b);
        busB.in_valid = 1'b1;
        busB.op       = op;
        busB.a_value  = a;
        busB.b_value  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        busA.in_valid = 1'b0;
        busB.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        busA.in_valid = 1'b0; busA.op = 3'd0; busA.a_value = '0; busA.b_value = '0;
        busB.in_valid = 1'b0; busB.op = 3'd0; busB.a_value = '0; busB.b_value = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_c",     busA.c_value,   0);
        checkOutput("rst_cmp",   busA.cmp,       0);
        checkOutput("rst_valid", busA.out_valid, 0);
        checkOutput("rstB_c",    busB.c_value,   0);
        rst_n = 1'b1;

        // ADD 1.5 + 2.25, one-cycle valid pulse
        applyStimulus(3'd1, 16'sd384, 16'sd576);
        checkOutput("add_c",     busA.c_value,   960);
        checkOutput("add_cmp",   busA.cmp,       3'b001);
        checkOutput("add_valid", busA.out_valid, 1);
        idleCycle();
        checkOutput("add_valid_drop", busA.out_valid, 0);
        checkOutput("add_hold",       busA.c_value,   960);

        // MUL with floor on realignment
        applyStimulus(3'd0, 16'sd384, -16'sd512);
        checkOutput("mul_c",     busA.c_value, -768);
        checkOutput("mul_cmp",   busA.cmp,     3'b100);
        applyStimulus(3'd0, -16'sd1, 16'sd1);
        checkOutput("mul_floor_neg", busA.c_value, -1);
        applyStimulus(3'd0, 16'sd1, 16'sd1);
        checkOutput("mul_floor_pos", busA.c_value, 0);

        // Wrap and NEG edge cases
        applyStimulus(3'd1, 16'sd32767, 16'sd1);
        checkOutput("add_wrap",     busA.c_value, -32768);
        checkOutput("add_wrap_cmp", busA.cmp,     3'b100);
        applyStimulus(3'd3, -16'sd32768, 16'sd0);
        checkOutput("neg_min",     busA.c_value, -32768);
        checkOutput("neg_min_cmp", busA.cmp,     3'b001);
        applyStimulus(3'd3, 16'sd384, 16'sd0);
        checkOutput("neg_pos", busA.c_value, -384);
        applyStimulus(3'd2, 16'sd0, 16'sd256);
        checkOutput("sub_c", busA.c_value, -256);

        // MIN / MAX / CMP
        applyStimulus(3'd4, -16'sd256, 16'sd128);
        checkOutput("min_c", busA.c_value, -256);
        applyStimulus(3'd5, -16'sd256, 16'sd128);
        checkOutput("max_c", busA.c_value, 128);
        applyStimulus(3'd4, 16'sd300, 16'sd128);
        checkOutput("min_b", busA.c_value, 128);
        applyStimulus(3'd7, -16'sd256, 16'sd128);
        checkOutput("cmp_c",  busA.c_value, 0);
        checkOutput("cmp_lt", busA.cmp,     3'b001);
        applyStimulus(3'd7, 16'sd128, 16'sd128);
        checkOutput("cmp_eq", busA.cmp, 3'b010);
        applyStimulus(3'd6, 16'sd77, 16'sd5);
        checkOutput("pass_c",  busA.c_value, 77);
        checkOutput("pass_gt", busA.cmp,     3'b100);
        idleCycle();

        // Mixed formats
        applyStimulusMixed(3'd1, 16'sd24, 16'sd256);
        checkOutput("mix_add",     busB.c_value,   160);
        checkOutput("mix_add_cmp", busB.cmp,       3'b100);
        checkOutput("mix_valid",   busB.out_valid, 1);
        applyStimulusMixed(3'd6, -16'sd1, 16'sd0);
        checkOutput("mix_pass",     busB.c_value, -4);
        checkOutput("mix_pass_cmp", busB.cmp,     3'b001);
        applyStimulusMixed(3'd7, 16'sd16, 16'sd256);
        checkOutput("mix_cmp_eq", busB.cmp,     3'b010);
        checkOutput("mix_cmp_c",  busB.c_value, 0);
        applyStimulusMixed(3'd0, 16'sd24, 16'sd256);
        checkOutput("mix_mul", busB.c_value, 96);
        idleCycle();

        // Back-to-back ops, then idle holds the last result
        applyStimulus(3'd1, 16'sd1, 16'sd2);
        checkOutput("b2b_1_valid", busA.out_valid, 1);
        checkOutput("b2b_1_c",     busA.c_value,   3);
        applyStimulus(3'd1, 16'sd10, 16'sd20);
        checkOutput("b2b_2_valid", busA.out_valid, 1);
        checkOutput("b2b_2_c",     busA.c_value,   30);
        applyStimulus(3'd2, 16'sd5, 16'sd7);
        checkOutput("b2b_3_valid", busA.out_valid, 1);
        checkOutput("b2b_3_c",     busA.c_value,   -2);
        idleCycle();
        checkOutput("b2b_idle_valid", busA.out_valid, 0);
        checkOutput("b2b_idle_c",     busA.c_value,   -2);
        checkOutput("b2b_idle_cmp",   busA.cmp,       3'b001);

        // Asynchronous reset mid-operation
        applyStimulus(3'd1, 16'sd100, 16'sd1);
        checkOutput("pre_rst_c", busA.c_value, 101);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_c",     busA.c_value,   0);
        checkOutput("async_rst_cmp",   busA.cmp,       0);
        checkOutput("async_rst_valid", busA.out_valid, 0);
        @(posedge clk);
        #1;
        checkOutput("in_rst_valid", busA.out_valid, 0);
        checkOutput("in_rst_c",     busA.c_value,   0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_valid", busA.out_valid, 1);
        checkOutput("post_rst_c",     busA.c_value,   101);
        idleCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/svreal_alu_reg.md
# svreal_alu_reg

Registered fixed-point arithmetic/compare unit for svreal-format numbers. Each operand is a signed integer `value` scaled by 2^exponent, so real = value·2^exponent. Per-port width and exponent are elaboration-time parameters. A runtime opcode selects one operation; the result is realigned to the output format and registered with a one-cycle valid pipeline. The unit sits in datapaths built from svreal numbers where a clocked, single-instance ALU replaces chains of combinational svreal macros.

## Interface
- `A_WIDTH`, default 16: bit width of operand a.
- `A_EXP`, default -8: exponent of operand a.
- `B_WIDTH`, default 16: bit width of operand b.
- `B_EXP`, default -8: exponent of operand b.
- `C_WIDTH`, default 16: bit width of result c.
- `C_EXP`, default -8: exponent of result c.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: operands and opcode are valid this cycle.
- `op`, input, 3: operation select (see Operation).
- `a_value`, input, signed A_WIDTH: operand a.
- `b_value`, input, signed B_WIDTH: operand b.
- `c_value`, output, signed C_WIDTH: registered result.
- `cmp`, output, 3: registered compare flags {gt, eq, lt} of a vs b.
- `out_valid`, output, 1: `c_value` and `cmp` were updated on the last edge.

## Operation
Alignment rule, align(x, Ex → Et, Wt):
- Let s = Ex − Et.
- If s ≥ 0: x <<< s.
- If s < 0: x >>> −s. This is an arithmetic shift, i.e. floor toward −∞.
- The result is truncated to Wt bits (two's-complement wrap). There is no saturation.

Opcodes:
- 0 MUL: full product p = a·b, signed, A_WIDTH+B_WIDTH bits, exponent A_EXP+B_EXP. c = align(p → C).
- 1 ADD: c = align(a → C) + align(b → C), computed modulo 2^C_WIDTH.
- 2 SUB: c = align(a → C) − align(b → C), computed modulo 2^C_WIDTH.
- 3 NEG: c = −align(a → C) in C_WIDTH bits. Negating the most-negative value returns the most-negative value.
- 4 MIN: c = align(b → C) if b < a (compare rule below), else align(a → C).
- 5 MAX: c = align(b → C) if b > a, else align(a → C).
- 6 PASS: c = align(a → C).
- 7 CMP: c = 0. The flags are the intended result.

Compare rule:
- Align both operands to exponent E = max(A_EXP, B_EXP) using the alignment rule, at widths A_WIDTH−(E−A_EXP) and B_WIDTH−(E−B_EXP) respectively.
- Compare as signed.
- `cmp` = {a>b, a==b, a<b}. Exactly one bit is set.
- `cmp` is updated for every accepted operation, not only for CMP.

Datapath structure:
- The datapath is purely combinational from the inputs to the output register.
- The opcode is sampled together with the operands.

## Timing
- Latency is 1 cycle. When `in_valid`=1 at edge k, `c_value`/`cmp` take the computed values at edge k and `out_valid`=1 during cycle k+1.
- When `in_valid`=0 at an edge, `c_value` and `cmp` hold their previous values and `out_valid` becomes 0.
- Throughput is one operation per cycle. Back-to-back valid inputs produce back-to-back valid outputs, with no bubbles and no backpressure.
- Reset values: `c_value`=0, `cmp`=3'b000, `out_valid`=0.
- Reset mid-operation: outputs clear immediately on `rst_n` falling, independent of `clk`. The in-flight operation is discarded.
- While `rst_n`=0, inputs are ignored.
- The first accepted operation is the one with `in_valid`=1 at the first rising edge after `rst_n` rises.

## Test plan
Default parameters apply unless noted (real = value/256).

1. ADD 1.5 + 2.25: a=384, b=576, op=1 → c=960 (3.75), cmp=001 (lt), `out_valid` high exactly one cycle after `in_valid`.
2. MUL 1.5 · −2.0: a=384, b=−512, op=0 → c=−768. Floor on realignment: a=−1, b=1, op=0 → c=−1. a=1, b=1, op=0 → c=0.
3. Wrap and NEG edge cases:
   - ADD a=32767, b=1 → c=−32768.
   - NEG a=−32768 → c=−32768.
   - SUB a=0, b=256 → c=−256.
4. MIN/MAX/CMP with a=−256 (−1.0), b=128 (0.5):
   - op=4 → c=−256.
   - op=5 → c=128.
   - op=7 → c=0, cmp=001.
   - With a=b=128, op=7 → cmp=010.
5. Mixed formats: A_EXP=−4, B_EXP=−8, C_WIDTH=12, C_EXP=−6.
   - a=24 (1.5) + b=256 (1.0), op=1 → c=160 (2.5).
   - op=6 with a=−1 → c=−4.
   - Compare with a=16, b=256 → cmp=010.
6. Handshake and reset:
   - Drive 3 consecutive valid ops, then 1 idle cycle → 3 consecutive `out_valid` pulses, then `c_value` holds the third result.
   - Pull `rst_n` low between clock edges while `in_valid`=1 → `c_value`=0, `cmp`=000, `out_valid`=0 immediately.
